// File: rtl/cond_unit_pkg.sv
// Shared definitions for the condition unit: condition codes, NZCV bit
// positions and the flag vector type.
package cond_unit_pkg;

   typedef logic [3:0] nzcv_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/cond_unit_check.sv
// Combinational condition evaluation: 4-bit condition field against NZCV.
module cond_check
   import cond_unit_pkg::*;
#(
   parameter bit NV_EXEC = 1'b0
) (
   input  logic [3:0] cond,
   input  nzcv_t      flags,
   output logic       pass
);

   logic n, z, c, v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   // Decode the condition field into a single pass bit
   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = ~z;
         COND_CS: pass = c;
         COND_CC: pass = ~c;
         COND_MI: pass = n;
         COND_PL: pass = ~n;
         COND_VS: pass = v;
         COND_VC: pass = ~v;
         COND_HI: pass = c & ~z;
         COND_LS: pass = ~c | z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = ~z & (n == v);
         COND_LE: pass = z | (n != v);
         COND_AL: pass = 1'b1;
         default: pass = NV_EXEC;
      endcase
   end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition unit: architectural NZCV register, shadow copy for
// exception entry/return, and condition gating of the write strobes.
module cond_unit
   import cond_unit_pkg::*;
#(
   parameter bit HAS_SHADOW = 1'b1,
   parameter bit NV_EXEC    = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       valid,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic [1:0] FlagW,
   input  logic       PCS,
   input  logic       RegW,
   input  logic       MemW,
   input  logic       NoWrite,
   input  logic       save_flags,
   input  logic       restore_flags,
   output logic       CondEx,
   output logic       PCSrc,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic [3:0] Flags,
   output logic [3:0] saved_flags
);

   nzcv_t flags_q, saved_q;
   nzcv_t flags_nxt, saved_nxt;
   logic  pass;

   // Condition is checked against the registered flags only; a flag update
   // becomes visible to the next instruction, never the one producing it.
   cond_check #(.NV_EXEC(NV_EXEC)) u_check (
      .cond  (Cond),
      .flags (flags_q),
      .pass  (pass)
   );

   assign CondEx   = reset & valid & pass;
   assign PCSrc    = PCS & CondEx;
   assign RegWrite = RegW & CondEx & ~NoWrite;
   assign MemWrite = MemW & CondEx;

   // Next-state selection: ALU write per half, then restore overrides it
   always_comb begin
      flags_nxt = flags_q;
      saved_nxt = saved_q;
      if (CondEx) begin
         if (FlagW[1]) flags_nxt[FLAG_N:FLAG_Z] = ALUFlags[FLAG_N:FLAG_Z];
         if (FlagW[0]) flags_nxt[FLAG_C:FLAG_V] = ALUFlags[FLAG_C:FLAG_V];
      end
      if (HAS_SHADOW) begin
         // Both use the old values, so save+restore together is a swap
         if (restore_flags) flags_nxt = saved_q;
         if (save_flags)    saved_nxt = flags_q;
      end
   end

   // Flag and shadow registers; reset wins over en, stall holds everything
   always_ff @(posedge clk) begin
      if (!reset) begin
         flags_q <= '0;
         saved_q <= '0;
      end else if (en) begin
         flags_q <= flags_nxt;
         saved_q <= saved_nxt;
      end
   end

   assign Flags       = flags_q;
   assign saved_flags = saved_q;

endmodule
